// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: the debug FSM state encoding,
// the drain default and register-index constants.
package pipe_ctrl_pkg;

  localparam int REG_W         = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam int DRAIN_CYC_DEF = 3;
  localparam int DCNT_W        = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// RAW hazard detector: compares the ID source operands against the EXE and MEM destinations.
// WB is never a hazard because the register file writes before it reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter bit FORWARD = 1'b0
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_reg_write,
  input  logic [REG_W-1:0] exe_wreg,
  input  logic             exe_lw,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_wreg,
  output logic             haz
);

  logic match_exe;
  logic match_mem;

  assign match_exe = exe_reg_write && (exe_wreg != REG_ZERO) &&
                     ((id_use_rs && (id_rs == exe_wreg)) || (id_use_rt && (id_rt == exe_wreg)));
  assign match_mem = mem_reg_write && (mem_wreg != REG_ZERO) &&
                     ((id_use_rs && (id_rs == mem_wreg)) || (id_use_rt && (id_rt == mem_wreg)));

  // With forwarding only a load in EXE cannot supply its result in time.
  assign haz = FORWARD ? (match_exe && exe_lw) : (match_exe || match_mem);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a debug halt/single-step FSM
// and saturating stall and flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FORWARD   = 0,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             EXE_RegWrite,
  input  logic [REG_W-1:0] EXE_WReg,
  input  logic             EXE_LW,
  input  logic             MEM_RegWrite,
  input  logic [REG_W-1:0] MEM_WReg,
  input  logic             EXE_BranchTaken,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  output logic             PC_Stall,
  output logic             IFID_Stall,
  output logic             IFID_Flush,
  output logic             ID_shouldstall,
  output logic             dbg_halted,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam logic [DCNT_W-1:0] CNT_INIT = DCNT_W'(DRAIN_CYC - 1);

  state_t            state, state_n;
  logic [DCNT_W-1:0] cnt, cnt_n;
  logic              haz;
  logic              stall_evt;

  hazard_detect #(.FORWARD(FORWARD != 0)) u_hazard_detect (
    .id_rs         (ID_Rs),
    .id_rt         (ID_Rt),
    .id_use_rs     (ID_UseRs),
    .id_use_rt     (ID_UseRt),
    .exe_reg_write (EXE_RegWrite),
    .exe_wreg      (EXE_WReg),
    .exe_lw        (EXE_LW),
    .mem_reg_write (MEM_RegWrite),
    .mem_wreg      (MEM_WReg),
    .haz           (haz)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      // A taken branch in EXE defers the halt so the redirect completes first.
      RUN: begin
        if (dbg_halt_req && !EXE_BranchTaken) begin
          state_n = DRAIN;
          cnt_n   = CNT_INIT;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_n = HALTED;
        else           cnt_n   = cnt - 1'b1;
      end
      HALTED: begin
        if (!dbg_halt_req) state_n = RUN;
        else if (dbg_step) state_n = STEP;
      end
      STEP: begin
        if (!haz) begin
          state_n = DRAIN;
          cnt_n   = CNT_INIT;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    PC_Stall       = 1'b0;
    IFID_Stall     = 1'b0;
    IFID_Flush     = 1'b0;
    ID_shouldstall = 1'b0;
    stall_evt      = 1'b0;
    if (EXE_BranchTaken) begin
      IFID_Flush     = 1'b1;
      ID_shouldstall = 1'b1;
    end else if ((state == DRAIN) || (state == HALTED)) begin
      PC_Stall       = 1'b1;
      IFID_Stall     = 1'b1;
      ID_shouldstall = 1'b1;
    end else if (haz) begin
      PC_Stall       = 1'b1;
      IFID_Stall     = 1'b1;
      ID_shouldstall = 1'b1;
      stall_evt      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      dbg_halted <= 1'b0;
      Stall_Cnt  <= '0;
      Flush_Cnt  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dbg_halted <= (state_n == HALTED);
      if (stall_evt && (Stall_Cnt != '1))       Stall_Cnt <= Stall_Cnt + 1'b1;
      if (EXE_BranchTaken && (Flush_Cnt != '1)) Flush_Cnt <= Flush_Cnt + 1'b1;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with forwarding, one without,
// both with 4-bit counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CW = 4;
  localparam logic [3:0] NO = 4'b0000;  // {PC_Stall, IFID_Stall, IFID_Flush, ID_shouldstall}
  localparam logic [3:0] SV = 4'b1101;
  localparam logic [3:0] FL = 4'b0011;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs, rt, ew, mw;
  logic urs, urt, ewe, lw, mwe, br, hreq, stp;

  logic pc_f, ifs_f, iff_f, ids_f, h_f;
  logic pc_n, ifs_n, iff_n, ids_n, h_n;
  logic [1:0] st_f, st_n;
  logic [CW-1:0] sc_f, fc_f, sc_n, fc_n;

  logic [29:0] exp_q[$];
  string       nm_q[$];
  int checks = 0;
  int failures = 0;
  int scf = 0, fcf = 0, scn = 0, fcn = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FORWARD(1), .DRAIN_CYC(3), .CNT_W(CW)) dut_f (
    .clk(clk), .rst(rst), .ID_Rs(rs), .ID_Rt(rt), .ID_UseRs(urs), .ID_UseRt(urt),
    .EXE_RegWrite(ewe), .EXE_WReg(ew), .EXE_LW(lw), .MEM_RegWrite(mwe), .MEM_WReg(mw),
    .EXE_BranchTaken(br), .dbg_halt_req(hreq), .dbg_step(stp),
    .PC_Stall(pc_f), .IFID_Stall(ifs_f), .IFID_Flush(iff_f), .ID_shouldstall(ids_f),
    .dbg_halted(h_f), .State(st_f), .Stall_Cnt(sc_f), .Flush_Cnt(fc_f)
  );

  pipeline_hazard_ctrl #(.FORWARD(0), .DRAIN_CYC(3), .CNT_W(CW)) dut_n (
    .clk(clk), .rst(rst), .ID_Rs(rs), .ID_Rt(rt), .ID_UseRs(urs), .ID_UseRt(urt),
    .EXE_RegWrite(ewe), .EXE_WReg(ew), .EXE_LW(lw), .MEM_RegWrite(mwe), .MEM_WReg(mw),
    .EXE_BranchTaken(br), .dbg_halt_req(hreq), .dbg_step(stp),
    .PC_Stall(pc_n), .IFID_Stall(ifs_n), .IFID_Flush(iff_n), .ID_shouldstall(ids_n),
    .dbg_halted(h_n), .State(st_n), .Stall_Cnt(sc_n), .Flush_Cnt(fc_n)
  );

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    logic [29:0] act, e;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      act = {pc_f, ifs_f, iff_f, ids_f, st_f, h_f, sc_f, fc_f,
             pc_n, ifs_n, iff_n, ids_n, st_n, h_n, sc_n, fc_n};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, e, $time);
      end
    end
  end

  task automatic idle();
    rs = 0; rt = 0; urs = 0; urt = 0; ewe = 0; ew = 0; lw = 0;
    mwe = 0; mw = 0; br = 0; stp = 0;
  endtask

  task automatic load_use();
    idle();
    ewe = 1; ew = 5; lw = 1; rs = 5; urs = 1;
  endtask

  // Push the hand-computed response for the current cycle, then advance one edge.
  task automatic chk(input string nm, input logic [3:0] of, input logic [3:0] on,
                     input logic [1:0] st, input logic h);
    exp_q.push_back({of, st, h, 4'(scf), 4'(fcf), on, st, h, 4'(scn), 4'(fcn)});
    nm_q.push_back(nm);
    @(posedge clk);
    if (rst) begin
      scf = 0; fcf = 0; scn = 0; fcn = 0;
    end else begin
      if (of == SV && (st == 2'(RUN) || st == 2'(STEP)) && scf < 15) scf++;
      if (on == SV && (st == 2'(RUN) || st == 2'(STEP)) && scn < 15) scn++;
      if (br && fcf < 15) fcf++;
      if (br && fcn < 15) fcn++;
    end
    #1;
  endtask

  initial begin
    rst = 1; hreq = 0; idle();
    @(posedge clk); #1;
    chk("reset", NO, NO, 2'(RUN), 0);
    load_use();
    chk("rst_comb", SV, SV, 2'(RUN), 0);
    rst = 0;
    load_use();
    chk("load_use", SV, SV, 2'(RUN), 0);
    load_use(); lw = 0;
    chk("no_load", NO, SV, 2'(RUN), 0);
    idle(); ewe = 1; ew = 0; rs = 0; urs = 1;
    chk("zero_reg", NO, NO, 2'(RUN), 0);
    idle(); mwe = 1; mw = 7; rt = 7; urt = 0; rs = 3; urs = 1;
    chk("unused_rt", NO, NO, 2'(RUN), 0);
    urt = 1;
    chk("mem_raw", NO, SV, 2'(RUN), 0);
    br = 1;
    chk("br_over_haz", FL, FL, 2'(RUN), 0);
    idle();
    chk("post_br", NO, NO, 2'(RUN), 0);

    hreq = 1;
    chk("halt_req", NO, NO, 2'(RUN), 0);
    for (int i = 0; i < 3; i++) chk("drain", SV, SV, 2'(DRAIN), 0);
    chk("halted", SV, SV, 2'(HALTED), 1);
    hreq = 0;
    chk("release", SV, SV, 2'(HALTED), 1);
    chk("run_again", NO, NO, 2'(RUN), 0);

    hreq = 1;
    chk("halt_req2", NO, NO, 2'(RUN), 0);
    for (int i = 0; i < 3; i++) chk("drain2", SV, SV, 2'(DRAIN), 0);
    stp = 1;
    chk("step_req", SV, SV, 2'(HALTED), 1);
    load_use();
    for (int i = 0; i < 2; i++) chk("step_hold", SV, SV, 2'(STEP), 0);
    idle();
    chk("step_issue", NO, NO, 2'(STEP), 0);
    br = 1;
    chk("step_br", FL, FL, 2'(DRAIN), 0);
    idle();
    for (int i = 0; i < 2; i++) chk("step_drain", SV, SV, 2'(DRAIN), 0);
    chk("step_halted", SV, SV, 2'(HALTED), 1);
    hreq = 0;
    chk("release2", SV, SV, 2'(HALTED), 1);

    hreq = 1;
    chk("halt_req3", NO, NO, 2'(RUN), 0);
    rst = 1;
    chk("rst_drain", SV, SV, 2'(DRAIN), 0);
    rst = 0; hreq = 0;
    chk("post_rst", NO, NO, 2'(RUN), 0);

    hreq = 1;
    chk("halt_req4", NO, NO, 2'(RUN), 0);
    for (int i = 0; i < 3; i++) chk("drain4", SV, SV, 2'(DRAIN), 0);
    hreq = 0; stp = 1;
    chk("release_wins", SV, SV, 2'(HALTED), 1);
    chk("step_in_run", NO, NO, 2'(RUN), 0);
    stp = 0;
    chk("step_ignored", NO, NO, 2'(RUN), 0);

    load_use();
    for (int i = 0; i < 20; i++) chk("sat", SV, SV, 2'(RUN), 0);
    idle();
    chk("sat_final", NO, NO, 2'(RUN), 0);

    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
